// File: rtl/slave_fifo_responder.sv
// Slave-FIFO bus responder standing in for the USB controller: OUT endpoint (FIFOADR 00) and IN endpoint (FIFOADR 10).
// Define SLAVE_FIFO_ERR_STATUS_EN to build the sticky {bad_addr, overflow, underflow} status; otherwise err is tied low.
module slave_fifo_responder #(
    parameter int DEPTH     = 512,
    parameter int PKT_WORDS = 256
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [1:0]  FIFOADR,
    input  logic        SLOE,
    input  logic        SLRD,
    input  logic        SLWR,
    input  logic        PKTEND,
    inout  wire  [15:0] FD,
    output logic        FLAG_EMPTY,
    output logic        FLAG_FULL,
    input  logic [15:0] host_wr_data,
    input  logic        host_wr_en,
    output logic        host_wr_ready,
    output logic [15:0] host_rd_data,
    output logic        host_rd_valid,
    input  logic        host_rd_en,
    output logic [15:0] pkt_cnt,
    output logic [2:0]  err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] PKT_C    = CW'(PKT_WORDS);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [1:0]    ADR_OUT  = 2'b00;
    localparam logic [1:0]    ADR_IN   = 2'b10;

    logic [15:0]   out_mem_q [DEPTH];
    logic [15:0]   in_mem_q  [DEPTH];

    logic [AW-1:0] out_wr_ptr_q, out_wr_ptr_d, out_rd_ptr_q, out_rd_ptr_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic [15:0]   out_head_q, out_head_d;
    logic [AW-1:0] in_wr_ptr_q, in_wr_ptr_d, in_rd_ptr_q, in_rd_ptr_d;
    logic [CW-1:0] in_com_q, in_com_d, in_unc_q, in_unc_d;
    logic [15:0]   in_head_q, in_head_d;
    logic          flag_empty_q, flag_empty_d, flag_full_q, flag_full_d;
    logic          wr_ready_q, wr_ready_d, rd_valid_q, rd_valid_d;
    logic [15:0]   pkt_cnt_q, pkt_cnt_d;

    logic          out_bus_pop_s, out_host_push_s, in_bus_push_s, in_host_pop_s;
    logic [CW-1:0] in_unc_plus_s;
    logic          auto_commit_s, commit_s;

    // Qualify every strobe against the registered flags of the current cycle.
    always_comb begin
        out_bus_pop_s   = SLRD && (FIFOADR == ADR_OUT) && !flag_empty_q;
        out_host_push_s = host_wr_en && wr_ready_q;
        in_bus_push_s   = SLWR && (FIFOADR == ADR_IN) && !flag_full_q;
        in_host_pop_s   = host_rd_en && rd_valid_q;
    end

    // OUT endpoint next state; the head register sees a same-edge push into the slot it is about to present.
    always_comb begin
        out_wr_ptr_d = out_host_push_s ? (out_wr_ptr_q + PTR_ONE) : out_wr_ptr_q;
        out_rd_ptr_d = out_bus_pop_s ? (out_rd_ptr_q + PTR_ONE) : out_rd_ptr_q;
        out_cnt_d    = out_cnt_q + CW'(out_host_push_s) - CW'(out_bus_pop_s);
        out_head_d   = (out_host_push_s && (out_rd_ptr_d == out_wr_ptr_q))
                       ? host_wr_data : out_mem_q[out_rd_ptr_d];
        flag_empty_d = (out_cnt_d == CNT_ZERO);
        wr_ready_d   = (out_cnt_d != DEPTH_C);
    end

    // IN endpoint: words sit in the uncommitted region until a full packet or PKTEND releases them to the host.
    always_comb begin
        in_unc_plus_s = in_unc_q + CW'(in_bus_push_s);
        auto_commit_s = in_bus_push_s && (in_unc_plus_s == PKT_C);
        commit_s      = PKTEND || auto_commit_s;
        in_unc_d      = commit_s ? CNT_ZERO : in_unc_plus_s;
        in_com_d      = in_com_q - CW'(in_host_pop_s) + (commit_s ? in_unc_plus_s : CNT_ZERO);
        in_wr_ptr_d   = in_bus_push_s ? (in_wr_ptr_q + PTR_ONE) : in_wr_ptr_q;
        in_rd_ptr_d   = in_host_pop_s ? (in_rd_ptr_q + PTR_ONE) : in_rd_ptr_q;
        in_head_d     = (in_bus_push_s && (in_rd_ptr_d == in_wr_ptr_q))
                        ? FD : in_mem_q[in_rd_ptr_d];
        pkt_cnt_d     = pkt_cnt_q + 16'(commit_s);
        flag_full_d   = ((in_com_d + in_unc_d) == DEPTH_C);
        rd_valid_d    = (in_com_d != CNT_ZERO);
    end

    // Pointer, occupancy, flag and counter registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_wr_ptr_q <= {AW{1'b0}};
            out_rd_ptr_q <= {AW{1'b0}};
            out_cnt_q    <= CNT_ZERO;
            out_head_q   <= 16'h0000;
            in_wr_ptr_q  <= {AW{1'b0}};
            in_rd_ptr_q  <= {AW{1'b0}};
            in_com_q     <= CNT_ZERO;
            in_unc_q     <= CNT_ZERO;
            in_head_q    <= 16'h0000;
            flag_empty_q <= 1'b1;
            flag_full_q  <= 1'b0;
            wr_ready_q   <= 1'b1;
            rd_valid_q   <= 1'b0;
            pkt_cnt_q    <= 16'h0000;
        end else begin
            out_wr_ptr_q <= out_wr_ptr_d;
            out_rd_ptr_q <= out_rd_ptr_d;
            out_cnt_q    <= out_cnt_d;
            out_head_q   <= out_head_d;
            in_wr_ptr_q  <= in_wr_ptr_d;
            in_rd_ptr_q  <= in_rd_ptr_d;
            in_com_q     <= in_com_d;
            in_unc_q     <= in_unc_d;
            in_head_q    <= in_head_d;
            flag_empty_q <= flag_empty_d;
            flag_full_q  <= flag_full_d;
            wr_ready_q   <= wr_ready_d;
            rd_valid_q   <= rd_valid_d;
            pkt_cnt_q    <= pkt_cnt_d;
        end
    end

    // Buffer storage carries no reset; the cleared pointers make old contents unreachable.
    always_ff @(posedge CLK) begin
        if (out_host_push_s) begin
            out_mem_q[out_wr_ptr_q] <= host_wr_data;
        end
        if (in_bus_push_s) begin
            in_mem_q[in_wr_ptr_q] <= FD;
        end
    end

    assign FD            = SLOE ? out_head_q : 16'hzzzz;
    assign FLAG_EMPTY    = flag_empty_q;
    assign FLAG_FULL     = flag_full_q;
    assign host_wr_ready = wr_ready_q;
    assign host_rd_data  = in_head_q;
    assign host_rd_valid = rd_valid_q;
    assign pkt_cnt       = pkt_cnt_q;

`ifdef SLAVE_FIFO_ERR_STATUS_EN
    logic [2:0] err_q, err_d;
    logic       bad_addr_s, overflow_s, underflow_s;

    // Error events are judged on the raw strobes, before endpoint qualification.
    always_comb begin
        bad_addr_s  = (SLRD && (FIFOADR != ADR_OUT)) || (SLWR && (FIFOADR != ADR_IN));
        overflow_s  = SLWR && (FIFOADR == ADR_IN) && flag_full_q;
        underflow_s = SLRD && (FIFOADR == ADR_OUT) && flag_empty_q;
        err_d       = err_q | {bad_addr_s, overflow_s, underflow_s};
    end

    // Sticky status, cleared only by reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_q <= 3'b000;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 3'b000;
`endif

endmodule

// File: tb/tb_slave_fifo_responder.sv
// Self-checking bench for slave_fifo_responder: directed scenarios plus a randomized run against a queue-based model.
module tb_slave_fifo_responder;
    localparam int DEPTH = 16;
    localparam int PKT   = 4;
`ifdef SLAVE_FIFO_ERR_STATUS_EN
    localparam logic [2:0] ERR_MASK = 3'b111;
`else
    localparam logic [2:0] ERR_MASK = 3'b000;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  fifoadr;
    logic        sloe, slrd, slwr, pktend;
    logic [15:0] fd_val;
    wire  [15:0] fd_bus;
    logic        flag_empty, flag_full;
    logic [15:0] host_wr_data;
    logic        host_wr_en, host_wr_ready;
    logic [15:0] host_rd_data;
    logic        host_rd_valid, host_rd_en;
    logic [15:0] pkt_cnt;
    logic [2:0]  err;

    logic [15:0] m_out[$];
    logic [15:0] m_com[$];
    logic [15:0] m_unc[$];
    logic [15:0] m_pkt;
    logic [2:0]  m_err;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    // The master drives FD only while the responder is not driving it.
    assign fd_bus = sloe ? 16'hzzzz : fd_val;

    slave_fifo_responder #(.DEPTH(DEPTH), .PKT_WORDS(PKT)) dut (
        .CLK(clk), .RST(rst), .FIFOADR(fifoadr), .SLOE(sloe), .SLRD(slrd), .SLWR(slwr),
        .PKTEND(pktend), .FD(fd_bus), .FLAG_EMPTY(flag_empty), .FLAG_FULL(flag_full),
        .host_wr_data(host_wr_data), .host_wr_en(host_wr_en), .host_wr_ready(host_wr_ready),
        .host_rd_data(host_rd_data), .host_rd_valid(host_rd_valid), .host_rd_en(host_rd_en),
        .pkt_cnt(pkt_cnt), .err(err)
    );

    function automatic logic [2:0] exp_err();
        return m_err & ERR_MASK;
    endfunction

    // One clock of stimulus: model decides from pre-edge occupancy, applies after the edge, strobes drop at negedge.
    task automatic step();
        bit hpush, hpop, bpop, bpush, autoc;
        logic [15:0] wdata;
        hpush = host_wr_en && (m_out.size() < DEPTH);
        hpop  = host_rd_en && (m_com.size() > 0);
        bpop  = slrd && (fifoadr == 2'b00) && (m_out.size() > 0);
        bpush = slwr && (fifoadr == 2'b10) && ((m_com.size() + m_unc.size()) < DEPTH);
        if ((slrd && fifoadr != 2'b00) || (slwr && fifoadr != 2'b10)) m_err[2] = 1'b1;
        if (slwr && fifoadr == 2'b10 && !bpush) m_err[1] = 1'b1;
        if (slrd && fifoadr == 2'b00 && m_out.size() == 0) m_err[0] = 1'b1;
        wdata = fd_val;
        @(posedge clk);
        if (hpop) void'(m_com.pop_front());
        if (bpop) void'(m_out.pop_front());
        if (hpush) m_out.push_back(host_wr_data);
        if (bpush) m_unc.push_back(wdata);
        autoc = bpush && (m_unc.size() == PKT);
        if (pktend || autoc) begin
            while (m_unc.size() > 0) m_com.push_back(m_unc.pop_front());
            m_pkt = m_pkt + 16'd1;
        end
        @(negedge clk);
        slrd = 1'b0; slwr = 1'b0; pktend = 1'b0; host_wr_en = 1'b0; host_rd_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; fifoadr = 2'b00; sloe = 1'b0; slrd = 1'b0; slwr = 1'b0; pktend = 1'b0;
        fd_val = 16'h0000; host_wr_data = 16'h0000; host_wr_en = 1'b0; host_rd_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_out.delete(); m_com.delete(); m_unc.delete();
        m_pkt = 16'h0000; m_err = 3'b000;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (flag_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", flag_empty); end
        checks++; if (flag_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", flag_full); end
        checks++; if (host_wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", host_wr_ready); end
        checks++; if (host_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", host_rd_valid); end
        checks++; if (pkt_cnt !== 16'h0000) begin errors++; $display("FAIL reset_pkt got=%h exp=0000", pkt_cnt); end
        checks++; if (err !== 3'b000) begin errors++; $display("FAIL reset_err got=%b exp=000", err); end
    endtask

    task automatic test_out_stream();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            host_wr_data = 16'(i); host_wr_en = 1'b1; step();
        end
        sloe = 1'b1; fifoadr = 2'b00; #1;
        checks++; if (fd_bus !== 16'h0001) begin errors++; $display("FAIL out_first_fd got=%h exp=0001", fd_bus); end
        for (int i = 1; i <= 4; i++) begin
            slrd = 1'b1; step();
            if (i < 4) begin
                checks++; if (fd_bus !== 16'(i + 1)) begin errors++; $display("FAIL out_fd got=%h exp=%h", fd_bus, 16'(i + 1)); end
                checks++; if (flag_empty !== 1'b0) begin errors++; $display("FAIL out_not_empty got=%b exp=0", flag_empty); end
            end
        end
        checks++; if (flag_empty !== 1'b1) begin errors++; $display("FAIL out_empty_after4 got=%b exp=1", flag_empty); end
        sloe = 1'b0;
    endtask

    task automatic test_in_packets();
        do_reset();
        fifoadr = 2'b10;
        for (int i = 0; i < 6; i++) begin
            fd_val = 16'hA000 + 16'(i); slwr = 1'b1; step();
            if (i == 2) begin
                checks++; if (host_rd_valid !== 1'b0) begin errors++; $display("FAIL in_early_valid got=%b exp=0", host_rd_valid); end
            end
            if (i == 3) begin
                checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL in_auto_pkt got=%0d exp=1", pkt_cnt); end
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++; if (host_rd_valid !== 1'b1 || host_rd_data !== 16'hA000 + 16'(i)) begin
                errors++; $display("FAIL in_read v=%b d=%h exp_d=%h", host_rd_valid, host_rd_data, 16'hA000 + 16'(i)); end
            host_rd_en = 1'b1; step();
        end
        checks++; if (host_rd_valid !== 1'b0) begin errors++; $display("FAIL in_partial_hidden got=%b exp=0", host_rd_valid); end
        pktend = 1'b1; step();
        checks++; if (pkt_cnt !== 16'd2) begin errors++; $display("FAIL in_pktend_cnt got=%0d exp=2", pkt_cnt); end
        for (int i = 4; i < 6; i++) begin
            checks++; if (host_rd_valid !== 1'b1 || host_rd_data !== 16'hA000 + 16'(i)) begin
                errors++; $display("FAIL in_tail v=%b d=%h exp_d=%h", host_rd_valid, host_rd_data, 16'hA000 + 16'(i)); end
            host_rd_en = 1'b1; step();
        end
        checks++; if (host_rd_valid !== 1'b0) begin errors++; $display("FAIL in_drained got=%b exp=0", host_rd_valid); end
    endtask

    task automatic test_full_overflow();
        logic [15:0] exp_w;
        do_reset();
        fifoadr = 2'b10;
        for (int i = 0; i < DEPTH; i++) begin
            fd_val = 16'($urandom_range(0, 16'hBFFF)); slwr = 1'b1; step();
        end
        checks++; if (flag_full !== 1'b1) begin errors++; $display("FAIL full_flag got=%b exp=1", flag_full); end
        checks++; if (pkt_cnt !== 16'(DEPTH / PKT)) begin errors++; $display("FAIL full_pkt got=%0d exp=%0d", pkt_cnt, DEPTH / PKT); end
        fd_val = 16'hDEAD; slwr = 1'b1; step();
        checks++; if (err !== (3'b010 & ERR_MASK)) begin errors++; $display("FAIL overflow_err got=%b exp=%b", err, 3'b010 & ERR_MASK); end
        for (int i = 0; i < DEPTH; i++) begin
            exp_w = m_com[0];
            checks++; if (host_rd_data !== exp_w || host_rd_data === 16'hDEAD) begin
                errors++; $display("FAIL full_drain got=%h exp=%h", host_rd_data, exp_w); end
            host_rd_en = 1'b1; step();
            if (i == 0) begin
                checks++; if (flag_full !== 1'b0) begin errors++; $display("FAIL full_release got=%b exp=0", flag_full); end
            end
        end
        checks++; if (host_rd_valid !== 1'b0) begin errors++; $display("FAIL full_dropped_visible got=%b exp=0", host_rd_valid); end
    endtask

    task automatic test_zero_len();
        do_reset();
        fifoadr = 2'b00; pktend = 1'b1; step();
        checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL zlp_cnt got=%0d exp=1", pkt_cnt); end
        checks++; if (host_rd_valid !== 1'b0) begin errors++; $display("FAIL zlp_valid got=%b exp=0", host_rd_valid); end
        slrd = 1'b1; step();
        checks++; if (err !== (3'b001 & ERR_MASK)) begin errors++; $display("FAIL underflow_err got=%b exp=%b", err, 3'b001 & ERR_MASK); end
        checks++; if (flag_empty !== 1'b1) begin errors++; $display("FAIL underflow_empty got=%b exp=1", flag_empty); end
    endtask

    task automatic test_bad_addr_reset();
        do_reset();
        pktend = 1'b1; step();
        fifoadr = 2'b00; fd_val = 16'h1234; slwr = 1'b1; step();
        checks++; if (flag_full !== 1'b0 || host_rd_valid !== 1'b0 || pkt_cnt !== 16'd1) begin
            errors++; $display("FAIL bad_addr_noop full=%b valid=%b pkt=%0d exp=0,0,1", flag_full, host_rd_valid, pkt_cnt); end
        checks++; if (err !== (3'b100 & ERR_MASK)) begin errors++; $display("FAIL bad_addr_err got=%b exp=%b", err, 3'b100 & ERR_MASK); end
        for (int i = 0; i < 3; i++) begin
            host_wr_data = 16'h5000 + 16'(i); host_wr_en = 1'b1; step();
        end
        sloe = 1'b1; slrd = 1'b1; step();
        checks++; if (flag_empty !== 1'b0 || fd_bus !== 16'h5001) begin
            errors++; $display("FAIL pre_reset empty=%b fd=%h exp=0,5001", flag_empty, fd_bus); end
        slrd = 1'b1; rst = 1'b1; #1;
        checks++; if (flag_empty !== 1'b1) begin errors++; $display("FAIL midreset_empty got=%b exp=1", flag_empty); end
        checks++; if (pkt_cnt !== 16'h0000) begin errors++; $display("FAIL midreset_pkt got=%0d exp=0", pkt_cnt); end
        checks++; if (err !== 3'b000) begin errors++; $display("FAIL midreset_err got=%b exp=000", err); end
        do_reset();
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            sloe = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 15);
            fifoadr = (r == 0) ? 2'b01 : (r == 1) ? 2'b11 : (r < 9) ? 2'b00 : 2'b10;
            slrd = 1'($urandom_range(0, 1));
            slwr = !sloe && ($urandom_range(0, 2) != 0);
            fd_val = 16'($urandom);
            pktend = ($urandom_range(0, 11) == 0);
            host_wr_data = 16'($urandom);
            host_wr_en = 1'($urandom_range(0, 1));
            host_rd_en = ($urandom_range(0, 2) == 0);
            step();
            checks++; if (flag_empty !== (m_out.size() == 0)) begin errors++; $display("FAIL rnd_empty n=%0d got=%b", n, flag_empty); end
            checks++; if (flag_full !== ((m_com.size() + m_unc.size()) == DEPTH)) begin errors++; $display("FAIL rnd_full n=%0d got=%b", n, flag_full); end
            checks++; if (host_wr_ready !== (m_out.size() != DEPTH)) begin errors++; $display("FAIL rnd_ready n=%0d got=%b", n, host_wr_ready); end
            checks++; if (host_rd_valid !== (m_com.size() != 0)) begin errors++; $display("FAIL rnd_valid n=%0d got=%b", n, host_rd_valid); end
            checks++; if (pkt_cnt !== m_pkt) begin errors++; $display("FAIL rnd_pkt n=%0d got=%0d exp=%0d", n, pkt_cnt, m_pkt); end
            checks++; if (err !== exp_err()) begin errors++; $display("FAIL rnd_err n=%0d got=%b exp=%b", n, err, exp_err()); end
            if (m_com.size() > 0) begin
                checks++; if (host_rd_data !== m_com[0]) begin errors++; $display("FAIL rnd_rd_data n=%0d got=%h exp=%h", n, host_rd_data, m_com[0]); end
            end
            if (sloe && m_out.size() > 0) begin
                checks++; if (fd_bus !== m_out[0]) begin errors++; $display("FAIL rnd_fd n=%0d got=%h exp=%h", n, fd_bus, m_out[0]); end
            end
        end
        sloe = 1'b0;
    endtask

    initial begin
        test_reset();
        test_out_stream();
        test_in_packets();
        test_full_overflow();
        test_zero_len();
        test_bad_addr_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/slave_fifo_responder.md
# slave_fifo_responder

- Cycle-accurate responder for the 16-bit synchronous slave-FIFO bus.
- Sits at the far end of the bus from our FPGA-side slave-FIFO master, in place of the USB controller, on bench and loopback builds.
- Holds two endpoint buffers:
  - OUT (host→FPGA), read by the master at FIFOADR 2'b00.
  - IN (FPGA→host), written by the master at FIFOADR 2'b10.
- Exposes a simple host-side push/pop port plus packet-commit accounting, so the master can be exercised without hardware.

## Interface
Parameters:
- DEPTH, 512: words per endpoint buffer; power of two, ≥4.
- PKT_WORDS, 256: IN auto-commit packet size in words; 1..DEPTH.

Ports:
- CLK  in  1  single clock; bus and host side both run on it.
- RST  in  1  asynchronous, active-high reset.
- FIFOADR  in  2  endpoint select from master.
- SLOE  in  1  1 = responder drives FD.
- SLRD  in  1  1-cycle pop strobe, OUT endpoint.
- SLWR  in  1  1-cycle push strobe, IN endpoint.
- PKTEND  in  1  1-cycle commit of the partial IN packet.
- FD  inout  16  bus data.
- FLAG_EMPTY  out  1  1 = OUT buffer empty.
- FLAG_FULL  out  1  1 = IN buffer full (committed + uncommitted words = DEPTH).
- host_wr_data  in  16  word to push into OUT.
- host_wr_en  in  1  push OUT; ignored when !host_wr_ready.
- host_wr_ready  out  1  OUT not full.
- host_rd_data  out  16  head of committed IN data (first-word fall-through).
- host_rd_valid  out  1  ≥1 committed IN word.
- host_rd_en  in  1  pop IN; ignored when !host_rd_valid.
- pkt_cnt  out  16  committed IN packets, wraps at 16'hFFFF→0.
- err  out  3  sticky {bad_addr, overflow, underflow}.

## Operation
- All bus inputs are sampled on posedge CLK.
- FD is driven with the OUT head word whenever SLOE=1; otherwise high-Z. FD is driven even when OUT is empty; the value is then don't-care.
- Pop OUT: SLRD=1 ∧ FIFOADR=2'b00 ∧ OUT non-empty.
  - SLRD=1 on an empty OUT → no pop, sets underflow.
- Push IN: SLWR=1 ∧ FIFOADR=2'b10 ∧ !FLAG_FULL. FD is captured on the same edge.
  - SLWR=1 while full → word dropped, sets overflow.
- SLRD or SLWR with a non-matching FIFOADR → no action, sets bad_addr.
- SLRD and SLWR together → both evaluated independently.
- IN commit state (uncommitted count U):
  - Push with U+1 = PKT_WORDS → U←0, words become committed, pkt_cnt+1.
  - PKTEND=1 (any FIFOADR) → all U words commit, including a same-edge push; pkt_cnt+1.
  - PKTEND with U=0 and no push → zero-length packet, pkt_cnt+1.
  - Auto-commit and PKTEND on the same edge → one packet only.
- Host and bus operations on the same buffer in the same cycle both succeed. Occupancy changes by the net amount.
- host_rd_valid and host_rd_en see committed words only.
- Reset values:
  - FLAG_EMPTY=1, FLAG_FULL=0.
  - host_wr_ready=1, host_rd_valid=0.
  - pkt_cnt=0, err=0.
  - FD high-Z unless SLOE=1; all buffers and counters cleared.
- Reset asserted mid-transfer discards all buffered data immediately.

## Timing
- Flags and ready/valid are registered from next-state occupancy, so they reflect an operation right after the edge that performs it. There is no extra lag.
- FD shows the new OUT head one cycle after a pop edge. It shows host data one cycle after a push into an empty OUT.
- host_rd_valid rises the cycle after the commit edge.
- Back-to-back strobes every cycle are supported. No wait states.

## Configuration
- SLAVE_FIFO_ERR_STATUS_EN:
  - Defined: err bits are sticky as above and clear only on RST.
  - Undefined: err is tied to 3'b000 and no error logic is built.
- Data-path behaviour is identical in both builds.

## Test plan
- Host pushes 16'h0001..16'h0004; master sets SLOE=1, then pulses SLRD ×4 at FIFOADR=00 → FD reads 1,2,3,4; FLAG_EMPTY=1 after the 4th pop edge.
- PKT_WORDS=4; master writes 16'hA000..A005 at FIFOADR=10 → pkt_cnt=1 after the 4th write; host_rd_valid shows 4 words; A004/A005 stay invisible until PKTEND, then pkt_cnt=2 and 6 words are readable.
- Fill IN to DEPTH with no host reads → FLAG_FULL=1; a further SLWR 16'hDEAD is dropped; err[1]=1 (macro on) or err=0 (macro off).
- PKTEND with U=0 → pkt_cnt 0→1, host_rd_valid stays 0; then SLRD on empty OUT → err[0]=1.
- SLWR at FIFOADR=00 → no IN change, err[2]=1. Then assert RST mid-burst with 3 OUT words present → FLAG_EMPTY=1, pkt_cnt=0, err=0 within the reset cycle.
